clk_enable_gen: RTL and testbench
=================================

CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 Parameter CHANNELS, default 4: number of clock-enable channels, legal 1..8.
REQ-002 Parameter DIV_WIDTH, default 16: divider register width, legal 2..32.
REQ-003 Parameter STABLE_CYCLES, default 256: consecutive synchronised-lock cycles required before run, legal 2..65535.
REQ-004 Parameter DIV_INIT, default 1: divider value loaded into every channel at reset.
REQ-005 clkIn  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pllLocked  in  1  asynchronous lock indication from the clock manager.
REQ-008 divValue  in  CHANNELS*DIV_WIDTH  packed divider values; channel i occupies bits [i*DIV_WIDTH +: DIV_WIDTH].
REQ-009 divLoad  in  1  single-cycle strobe capturing divValue into the pending registers.
REQ-010 clrLost  in  1  single-cycle strobe clearing lockLost.
REQ-011 clkEn  out  CHANNELS  per-channel one-cycle enable pulses.
REQ-012 sysReset  out  1  active-high reset for downstream logic.
REQ-013 isStable  out  1  high exactly while in RUN.
REQ-014 lockLost  out  1  sticky flag: lock dropped during RUN.

Function
REQ-015 pllLocked SHALL pass through a 2-flop synchroniser; lockS denotes the second flop output.
REQ-016 FSM states SHALL be WAIT_LOCK, STABILIZE, RUN, LOST.
REQ-017 WAIT_LOCK -> STABILIZE when lockS=1; stability counter cleared on entry.
REQ-018 STABILIZE: counter increments each cycle lockS=1; lockS=0 -> WAIT_LOCK; counter reaching STABLE_CYCLES-1 with lockS=1 -> RUN.
REQ-019 RUN -> LOST when lockS=0; LOST -> WAIT_LOCK unconditionally after one cycle.
REQ-020 sysReset SHALL be 1 in every state except RUN; isStable = (state==RUN), registered.
REQ-021 lockLost SHALL set on the RUN->LOST transition, clear on clrLost; simultaneous set and clear: set wins.
REQ-022 Each channel SHALL hold an active divider, a pending divider and a pending-valid bit, plus a DIV_WIDTH counter.
REQ-023 Outside RUN all counters SHALL be 0 and clkEn all 0; on first RUN cycle all counters start from 0 (channels phase-aligned).
REQ-024 In RUN, active divider D>=2: counter counts 0..D-1 and wraps; clkEn[i]=1 in the cycle counter==D-1, i.e. first pulse D-1 cycles after RUN entry, then period D.
REQ-025 D=1: clkEn[i] constantly 1 in RUN; D=0: channel disabled, clkEn[i]=0, counter held at 0.
REQ-026 divLoad SHALL copy each channel's divValue into pending and set pending-valid; a second divLoad before application overwrites pending.
REQ-027 Pending SHALL transfer to active (counter to 0, valid cleared) at the channel's wrap cycle, or immediately next cycle if active D is 0 or 1 or state is not RUN; no truncated or extra pulse is produced.
REQ-028 divLoad coincident with a wrap SHALL apply the new value at that wrap.
REQ-029 clkEn SHALL be registered: combinational from state and counters is forbidden.

Reset
REQ-030 reset SHALL force: state WAIT_LOCK, synchroniser flops 0, stability counter 0, all channel counters 0, active dividers DIV_INIT, pending-valid 0, clkEn 0, sysReset 1, isStable 0, lockLost 0.
REQ-031 reset during RUN SHALL take effect next edge without passing through LOST and without setting lockLost.

Structure
REQ-032 State encoding and a ceil-log2 width function SHALL live in a shared package clk_gen_pkg.
REQ-033 The per-channel divider (counter, active/pending registers, pulse) SHALL be one sub-module clk_enable_chan, instantiated CHANNELS times by generate.

Verification
REQ-034 STABLE_CYCLES=8, pllLocked rises at cycle 10 -> isStable and sysReset=0 from cycle 10+2+8 (+/-1 for registering, bench checks exact documented value), clkEn 0 before.
REQ-035 pllLocked drops 3 cycles into STABILIZE -> return to WAIT_LOCK, counter restarts, lockLost stays 0.
REQ-036 Dividers {0,1,3,5} in RUN -> ch0 never pulses, ch1 constant 1, ch2 pulses every 3rd cycle, ch3 every 5th, first pulses 2 and 4 cycles after RUN entry.
REQ-037 Channel at D=5, divLoad with 2 at counter=1 -> pulse at counter 4 as before, then period 2; no pulse missing or doubled.
REQ-038 pllLocked drops in RUN -> after 2-cycle sync LOST for one cycle, sysReset=1, clkEn=0, lockLost=1; clrLost clears it; clrLost coincident with set leaves it 1.
REQ-039 reset asserted in RUN with D=3 pending -> all outputs to reset values next cycle, pending discarded, active = DIV_INIT.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_gen_pkg
// Shared definitions for the clock-enable generator:
//   state_t  - lock-supervision FSM state encoding
//   clog2    - ceil-log2 width helper (never returns less than 1)
// -----------------------------------------------------------------------------
package clk_gen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2,
        LOST      = 2'd3
    } state_t;

    // Number of bits needed to hold the values 0..value-1.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((w < 31) && ((1 << w) < value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/clk_enable_chan.sv
// -----------------------------------------------------------------------------
// clk_enable_chan
// One clock-enable channel: programmable divider with a double-buffered
// divider value, producing a registered one-cycle enable pulse.
// Ports:
//   i_clk       clock (rising edge)
//   i_reset     synchronous active-high reset
//   i_run       high while the supervisor is in RUN this cycle
//   i_runNext   high when the supervisor will be in RUN next cycle
//   i_divLoad   strobe: capture i_divValue into the pending register
//   i_divValue  new divider value for this channel
//   o_clkEn     registered enable pulse
// -----------------------------------------------------------------------------
module clk_enable_chan #(
    parameter int DIV_WIDTH = 16,
    parameter int DIV_INIT  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_run,
    input  logic                 i_runNext,
    input  logic                 i_divLoad,
    input  logic [DIV_WIDTH-1:0] i_divValue,
    output logic                 o_clkEn
);

    localparam logic [DIV_WIDTH-1:0] INIT_D = DIV_WIDTH'(DIV_INIT);
    localparam logic [DIV_WIDTH-1:0] ONE    = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_active;
    logic [DIV_WIDTH-1:0] r_pend;
    logic                 r_pendV;
    logic                 r_clkEn;

    logic                 w_wrap;
    logic                 w_apply;
    logic [DIV_WIDTH-1:0] w_activeNext;
    logic [DIV_WIDTH-1:0] w_cntNext;
    logic                 w_enNext;

    always_comb begin
        // Current cycle is the pulse/wrap cycle of a D>=2 divider.
        w_wrap = i_run && (r_active > ONE) && (r_cnt == r_active - ONE);

        // A new divider takes effect at the wrap (a load arriving on the wrap
        // edge is taken directly), or straight away when there is no period
        // in progress to protect (not running, or D is 0/1). A fresh load in
        // the latter case overwrites pending and is applied one edge later.
        if (w_wrap) begin
            w_apply = i_divLoad || r_pendV;
        end else begin
            w_apply = (!i_run || (r_active <= ONE)) && r_pendV && !i_divLoad;
        end

        w_activeNext = r_active;
        if (w_apply) begin
            w_activeNext = i_divLoad ? i_divValue : r_pend;
        end

        // Counter restarts from 0 on RUN entry, on every wrap and on every
        // divider change, so all channels are phase-aligned at RUN entry.
        w_cntNext = '0;
        if (i_runNext && i_run && !w_apply && !w_wrap && (r_active > ONE)) begin
            w_cntNext = r_cnt + ONE;
        end

        // Pulse is computed from next-cycle state so the output can be a flop.
        w_enNext = i_runNext &&
                   ((w_activeNext == ONE) ||
                    ((w_activeNext > ONE) && (w_cntNext == w_activeNext - ONE)));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_active <= INIT_D;
            r_pendV  <= 1'b0;
            r_clkEn  <= 1'b0;
        end else begin
            r_cnt    <= w_cntNext;
            r_active <= w_activeNext;
            r_clkEn  <= w_enNext;
            if (i_divLoad && !w_wrap) begin
                r_pend  <= i_divValue;
                r_pendV <= 1'b1;
            end else if (w_apply) begin
                r_pendV <= 1'b0;
            end
        end
    end

    assign o_clkEn = r_clkEn;

endmodule

// File: rtl/clk_enable_gen.sv
// -----------------------------------------------------------------------------
// clk_enable_gen
// Lock supervisor plus CHANNELS programmable clock-enable dividers.
// Ports:
//   clkIn      sole clock (rising edge)
//   reset      synchronous active-high reset
//   pllLocked  asynchronous PLL lock indication
//   divValue   packed divider values, channel i at [i*DIV_WIDTH +: DIV_WIDTH]
//   divLoad    strobe: capture divValue into every channel's pending register
//   clrLost    strobe: clear lockLost
//   clkEn      per-channel registered enable pulses
//   sysReset   downstream reset, low only in RUN
//   isStable   high exactly while in RUN
//   lockLost   sticky: lock dropped while in RUN
// -----------------------------------------------------------------------------
module clk_enable_gen
    import clk_gen_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int DIV_WIDTH     = 16,
    parameter int STABLE_CYCLES = 256,
    parameter int DIV_INIT      = 1
) (
    input  logic                          clkIn,
    input  logic                          reset,
    input  logic                          pllLocked,
    input  logic [CHANNELS*DIV_WIDTH-1:0] divValue,
    input  logic                          divLoad,
    input  logic                          clrLost,
    output logic [CHANNELS-1:0]           clkEn,
    output logic                          sysReset,
    output logic                          isStable,
    output logic                          lockLost
);

    localparam int                 STAB_W    = clog2(STABLE_CYCLES);
    localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    state_t              r_state;
    logic                r_sync1;
    logic                r_lockS;
    logic [STAB_W-1:0]   r_stabCnt;
    logic                r_sysReset;
    logic                r_isStable;
    logic                r_lockLost;

    logic                w_enterRun;
    logic                w_runNext;

    // Decoded here as well as in the FSM so the channels can register their
    // pulses against the state the FSM is about to enter.
    always_comb begin
        w_enterRun = (r_state == STABILIZE) && r_lockS && (r_stabCnt == STAB_LAST);
        w_runNext  = !reset && (w_enterRun || ((r_state == RUN) && r_lockS));
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            r_state    <= WAIT_LOCK;
            r_sync1    <= 1'b0;
            r_lockS    <= 1'b0;
            r_stabCnt  <= '0;
            r_sysReset <= 1'b1;
            r_isStable <= 1'b0;
            r_lockLost <= 1'b0;
        end else begin
            r_sync1 <= pllLocked;
            r_lockS <= r_sync1;

            // Clear first so a coincident RUN->LOST set below overrides it.
            if (clrLost) begin
                r_lockLost <= 1'b0;
            end

            case (r_state)
                WAIT_LOCK: begin
                    if (r_lockS) begin
                        r_state   <= STABILIZE;
                        r_stabCnt <= '0;
                    end
                end
                STABILIZE: begin
                    if (!r_lockS) begin
                        r_state <= WAIT_LOCK;
                    end else if (w_enterRun) begin
                        r_state    <= RUN;
                        r_sysReset <= 1'b0;
                        r_isStable <= 1'b1;
                    end else begin
                        r_stabCnt <= r_stabCnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!r_lockS) begin
                        r_state    <= LOST;
                        r_sysReset <= 1'b1;
                        r_isStable <= 1'b0;
                        r_lockLost <= 1'b1;
                    end
                end
                LOST: begin
                    r_state <= WAIT_LOCK;
                end
                default: begin
                    r_state    <= WAIT_LOCK;
                    r_sysReset <= 1'b1;
                    r_isStable <= 1'b0;
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_chan
            clk_enable_chan #(
                .DIV_WIDTH (DIV_WIDTH),
                .DIV_INIT  (DIV_INIT)
            ) u_chan (
                .i_clk      (clkIn),
                .i_reset    (reset),
                .i_run      (r_isStable),
                .i_runNext  (w_runNext),
                .i_divLoad  (divLoad),
                .i_divValue (divValue[g*DIV_WIDTH +: DIV_WIDTH]),
                .o_clkEn    (clkEn[g])
            );
        end
    endgenerate

    assign sysReset = r_sysReset;
    assign isStable = r_isStable;
    assign lockLost = r_lockLost;

endmodule

// File: tb/tb_clk_enable_gen.sv
module tb_clk_enable_gen;

    localparam int CH = 4;
    localparam int DW = 8;
    localparam int SC = 8;
    localparam int DI = 1;

    logic              clkIn = 1'b0;
    logic              reset;
    logic              pllLocked;
    logic [CH*DW-1:0]  divValue;
    logic              divLoad;
    logic              clrLost;
    logic [CH-1:0]     clkEn;
    logic              sysReset;
    logic              isStable;
    logic              lockLost;

    int errors = 0;
    int checks = 0;

    clk_enable_gen #(
        .CHANNELS      (CH),
        .DIV_WIDTH     (DW),
        .STABLE_CYCLES (SC),
        .DIV_INIT      (DI)
    ) dut (
        .clkIn     (clkIn),
        .reset     (reset),
        .pllLocked (pllLocked),
        .divValue  (divValue),
        .divLoad   (divLoad),
        .clrLost   (clrLost),
        .clkEn     (clkEn),
        .sysReset  (sysReset),
        .isStable  (isStable),
        .lockLost  (lockLost)
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        logic       pll;
        logic       load;
        logic       clr;
        logic [3:0] en;
        logic       stable;
        logic       sys;
        logic       lost;
    } vec_t;

    vec_t tbl[26];

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, k, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    function automatic vec_t mk(input logic pll, input logic load, input logic clr,
                                input logic [3:0] en, input logic stable,
                                input logic sys, input logic lost);
        vec_t v;
        v.pll = pll; v.load = load; v.clr = clr;
        v.en = en; v.stable = stable; v.sys = sys; v.lost = lost;
        return v;
    endfunction

    task automatic check_all(input string tag, input int k, input logic [3:0] en,
                             input logic stable, input logic sys, input logic lost);
        check({tag, "_clkEn"},    k, 32'(clkEn),    32'(en));
        check({tag, "_isStable"}, k, 32'(isStable), 32'(stable));
        check({tag, "_sysReset"}, k, 32'(sysReset), 32'(sys));
        check({tag, "_lockLost"}, k, 32'(lockLost), 32'(lost));
    endtask

    initial begin
        // RUN-phase vectors; step 0 is the first RUN cycle, dividers {5,3,1,0}.
        // Step 11 loads ch3=2 while its counter is 1; step 19 drops lock;
        // step 21 clears on the same edge lockLost sets; step 23 clears it.
        //             pll  ld  clr  en       stb  sys  lost
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0);
        tbl[15] = mk(1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        tbl[16] = mk(1'b1, 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0);
        tbl[17] = mk(1'b1, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0);
        tbl[18] = mk(1'b1, 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0);
        tbl[19] = mk(1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        tbl[20] = mk(1'b0, 1'b0, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0);
        tbl[21] = mk(1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
        tbl[22] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        tbl[23] = mk(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
        tbl[24] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        tbl[25] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);

        reset     = 1'b1;
        pllLocked = 1'b0;
        divLoad   = 1'b0;
        clrLost   = 1'b0;
        divValue  = '0;
        tick(); tick(); tick();
        check_all("reset", 0, 4'b0000, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;

        // Load dividers {ch3=5, ch2=3, ch1=1, ch0=0} while waiting for lock.
        divValue = {8'd5, 8'd3, 8'd1, 8'd0};
        divLoad  = 1'b1;
        tick();
        divLoad = 1'b0;
        tick(); tick();

        // Lock drops three cycles into STABILIZE: no RUN, no lockLost.
        pllLocked = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 3) pllLocked = 1'b0;
            check("stab_drop_isStable", i, 32'(isStable), 32'd0);
            check("stab_drop_clkEn",    i, 32'(clkEn),    32'd0);
            check("stab_drop_lockLost", i, 32'(lockLost), 32'd0);
        end

        // Clean lock: RUN starts exactly 2 sync + 8 stabilise cycles later.
        pllLocked = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("prerun_isStable", i, 32'(isStable), 32'd0);
            check("prerun_sysReset", i, 32'(sysReset), 32'd1);
            check("prerun_clkEn",    i, 32'(clkEn),    32'd0);
        end
        tick();

        for (int k = 0; k < 26; k++) begin
            check_all("run", k, tbl[k].en, tbl[k].stable, tbl[k].sys, tbl[k].lost);
            pllLocked = tbl[k].pll;
            clrLost   = tbl[k].clr;
            divLoad   = tbl[k].load;
            if (tbl[k].load) divValue = {8'd2, 8'd3, 8'd1, 8'd0};
            tick();
        end
        divLoad = 1'b0;
        clrLost = 1'b0;

        // Reach RUN again, leave a D=3 load pending, then reset.
        pllLocked = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
        end
        check("rerun_isStable", 0, 32'(isStable), 32'd1);
        divValue = {8'd3, 8'd3, 8'd3, 8'd3};
        divLoad  = 1'b1;
        tick();
        divLoad = 1'b0;
        reset   = 1'b1;
        tick();
        check_all("run_reset", 0, 4'b0000, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;

        // Pending was discarded: every channel back to DIV_INIT=1, constant pulse.
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i < 11) begin
                check("postreset_isStable", i, 32'(isStable), 32'd0);
                check("postreset_clkEn",    i, 32'(clkEn),    32'd0);
            end
        end
        check_all("postreset_run", 0, 4'b1111, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        check_all("postreset_run", 2, 4'b1111, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
